// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-side hazard/flush interface between the ID stage and pipeline_hazard_ctrl.
// master = decode stage (drives instruction info), slave = hazard controller.
interface pipeline_hazard_ctrl_if;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic        id_rs_used;
  logic [4:0]  id_rt;
  logic        id_rt_used;
  logic        id_rfWE;
  logic [4:0]  id_rfDst;
  logic        id_is_load;
  logic        branch_taken;
  logic        stall_if;
  logic        stall_id;
  logic        bubble_ex;
  logic        flush_id;
  logic [31:0] busy_mask;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
           id_rfWE, id_rfDst, id_is_load, branch_taken,
    input  stall_if, stall_id, bubble_ex, flush_id, busy_mask
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
           id_rfWE, id_rfDst, id_is_load, branch_taken,
    output stall_if, stall_id, bubble_ex, flush_id, busy_mask
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Scoreboard hazard and flush controller for the 5-stage pipeline decode stage.
// Optional macro HAZARD_FWD_EN: forwarding present, only load-use stalls remain.
module pipeline_hazard_ctrl #(
  parameter int unsigned WB_LAT    = 3,
  parameter int unsigned FLUSH_CYC = 1
) (
  input logic                 clk,
  input logic                 rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int unsigned CW  = $clog2(WB_LAT + 1);
  localparam int unsigned FCW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC + 1) : 1;

  typedef enum logic {RUN, FLUSH} state_e;

  state_e          state_q;
  logic [FCW-1:0]  fcnt_q;
  logic [CW-1:0]   cnt_q [32];
  logic [CW-1:0]   cnt_d [32];
  logic [31:0]     ld_q;
  logic [31:0]     ld_d;
  logic [31:0]     blk_c;
  logic [31:0]     busy_c;
  logic            run_c;
  logic            vld_c;
  logic            hazard_c;
  logic            issue_c;
  logic            take_c;

  // Per-register "blocks a reader" and debug busy bits from the registered counters
  always_comb begin
    blk_c  = '0;
    busy_c = '0;
    for (int n = 1; n < 32; n++) begin
      busy_c[n] = (cnt_q[n] != '0);
`ifdef HAZARD_FWD_EN
      blk_c[n]  = ld_q[n] && (cnt_q[n] == CW'(WB_LAT));
`else
      blk_c[n]  = (cnt_q[n] != '0);
`endif
    end
  end

`ifndef HAZARD_FWD_EN
  // Load flags only matter when forwarding narrows stalls to load-use
  logic unused_ld;
  assign unused_ld = ^ld_q;
`endif

  // FLUSH masks the decode instruction entirely: no hazard, no issue
  assign run_c    = (state_q == RUN);
  assign vld_c    = hz.id_valid & run_c;
  assign hazard_c = vld_c & ((hz.id_rs_used & blk_c[hz.id_rs]) |
                             (hz.id_rt_used & blk_c[hz.id_rt]));
  assign issue_c  = vld_c & ~hazard_c & hz.id_rfWE & (hz.id_rfDst != 5'd0);
  assign take_c   = run_c & hz.branch_taken & ~hazard_c;

  assign hz.stall_if  = ~rst & hazard_c;
  assign hz.stall_id  = ~rst & hazard_c;
  assign hz.bubble_ex = ~rst & hazard_c;
  assign hz.flush_id  = ~rst & (take_c | (state_q == FLUSH));
  assign hz.busy_mask = rst ? 32'd0 : busy_c;

  // Scoreboard next state: age every pending write, a new issue reloads its entry
  always_comb begin
    ld_d = ld_q;
    for (int n = 0; n < 32; n++) begin
      cnt_d[n] = cnt_q[n];
      if (cnt_q[n] != '0) cnt_d[n] = cnt_q[n] - CW'(1);
    end
    if (issue_c) begin
      cnt_d[hz.id_rfDst] = CW'(WB_LAT);
      ld_d[hz.id_rfDst]  = hz.id_is_load;
    end
    cnt_d[0] = '0;
    ld_d[0]  = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 32; n++) cnt_q[n] <= '0;
      ld_q <= '0;
    end else begin
      for (int n = 0; n < 32; n++) cnt_q[n] <= cnt_d[n];
      ld_q <= ld_d;
    end
  end

  // Flush sequencer; the RUN cycle that takes the branch is the first flush cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (take_c && (FLUSH_CYC > 1)) begin
            state_q <= FLUSH;
            fcnt_q  <= FCW'(FLUSH_CYC - 1);
          end
        end
        FLUSH: begin
          if (fcnt_q == FCW'(1)) begin
            state_q <= RUN;
            fcnt_q  <= '0;
          end else begin
            fcnt_q  <= fcnt_q - FCW'(1);
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected outputs are queued per step
// and popped/compared on the falling edge; a FLUSH_CYC=3 instance covers long flushes.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic        sel3;
    logic        stall;
    logic        flush;
    logic [31:0] mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic use3 = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  pipeline_hazard_ctrl_if hif ();
  pipeline_hazard_ctrl_if hif3 ();

  pipeline_hazard_ctrl #(.WB_LAT(3), .FLUSH_CYC(1)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif.slave)
  );

  pipeline_hazard_ctrl #(.WB_LAT(3), .FLUSH_CYC(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .hz  (hif3.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Both instances see identical decode inputs
  task automatic drv(input logic v, input logic [4:0] rs, input logic rsu,
                     input logic [4:0] rt, input logic rtu, input logic we,
                     input logic [4:0] dst, input logic ld, input logic br);
    hif.id_valid  = v;   hif3.id_valid  = v;
    hif.id_rs     = rs;  hif3.id_rs     = rs;
    hif.id_rs_used = rsu; hif3.id_rs_used = rsu;
    hif.id_rt     = rt;  hif3.id_rt     = rt;
    hif.id_rt_used = rtu; hif3.id_rt_used = rtu;
    hif.id_rfWE   = we;  hif3.id_rfWE   = we;
    hif.id_rfDst  = dst; hif3.id_rfDst  = dst;
    hif.id_is_load = ld; hif3.id_is_load = ld;
    hif.branch_taken = br; hif3.branch_taken = br;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // One decode cycle: queue the expectation, compare mid-cycle, then clock
  task automatic step_chk(input string tag, input logic es, input logic ef,
                          input logic [31:0] em);
    exp_t e;
    exp_t p;
    e.sel3 = use3; e.stall = es; e.flush = ef; e.mask = em;
    exp_q.push_back(e);
    @(negedge clk);
    p = exp_q.pop_front();
    if (p.sel3) begin
      chk({tag, ".stall_if"},  32'(hif3.stall_if),  32'(p.stall));
      chk({tag, ".stall_id"},  32'(hif3.stall_id),  32'(p.stall));
      chk({tag, ".bubble_ex"}, 32'(hif3.bubble_ex), 32'(p.stall));
      chk({tag, ".flush_id"},  32'(hif3.flush_id),  32'(p.flush));
      chk({tag, ".busy_mask"}, hif3.busy_mask,      p.mask);
    end else begin
      chk({tag, ".stall_if"},  32'(hif.stall_if),  32'(p.stall));
      chk({tag, ".stall_id"},  32'(hif.stall_id),  32'(p.stall));
      chk({tag, ".bubble_ex"}, 32'(hif.bubble_ex), 32'(p.stall));
      chk({tag, ".flush_id"},  32'(hif.flush_id),  32'(p.flush));
      chk({tag, ".busy_mask"}, hif.busy_mask,      p.mask);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with inputs that would otherwise branch-flush: everything forced low
    rst = 1'b1;
    drv(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1);
    step_chk("reset", 1'b0, 1'b0, 32'h0);
    rst = 1'b0;

`ifndef HAZARD_FWD_EN
    // add $3 then a reader of $3: three stall cycles, then it issues $4
    drv(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    step_chk("t1_prod", 1'b0, 1'b0, 32'h0);
    drv(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
    step_chk("t1_s1", 1'b1, 1'b0, 32'h8);
    step_chk("t1_s2", 1'b1, 1'b0, 32'h8);
    step_chk("t1_s3", 1'b1, 1'b0, 32'h8);
    step_chk("t1_go", 1'b0, 1'b0, 32'h0);
    idle();
    step_chk("t1_d1", 1'b0, 1'b0, 32'h10);
    step_chk("t1_d2", 1'b0, 1'b0, 32'h10);
    step_chk("t1_d3", 1'b0, 1'b0, 32'h10);
    step_chk("t1_d4", 1'b0, 1'b0, 32'h0);
`endif

    // Writes to $0 are dropped and reading $0 never stalls
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    step_chk("t2_w0", 1'b0, 1'b0, 32'h0);
    drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    step_chk("t2_r0", 1'b0, 1'b0, 32'h0);

    // An instruction reading its own destination does not stall on itself
    drv(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
    step_chk("self", 1'b0, 1'b0, 32'h0);
    idle();
    step_chk("self_d1", 1'b0, 1'b0, 32'h200);
    step_chk("self_d2", 1'b0, 1'b0, 32'h200);
    step_chk("self_d3", 1'b0, 1'b0, 32'h200);
    step_chk("self_d4", 1'b0, 1'b0, 32'h0);

`ifndef HAZARD_FWD_EN
    // rs == rt both busy
    drv(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    step_chk("rr_prod", 1'b0, 1'b0, 32'h0);
    drv(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    step_chk("rr_s1", 1'b1, 1'b0, 32'h80);
    step_chk("rr_s2", 1'b1, 1'b0, 32'h80);
    step_chk("rr_s3", 1'b1, 1'b0, 32'h80);
    step_chk("rr_go", 1'b0, 1'b0, 32'h0);
`endif

    // Taken branch with no hazard: one flush cycle
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    step_chk("t3_br", 1'b0, 1'b1, 32'h0);
    idle();
    step_chk("t3_after", 1'b0, 1'b0, 32'h0);

`ifndef HAZARD_FWD_EN
    // Branch waiting on an operand: flush only once the stall clears
    drv(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0);
    step_chk("t4_prod", 1'b0, 1'b0, 32'h0);
    drv(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    step_chk("t4_s1", 1'b1, 1'b0, 32'h40);
    step_chk("t4_s2", 1'b1, 1'b0, 32'h40);
    step_chk("t4_s3", 1'b1, 1'b0, 32'h40);
    step_chk("t4_take", 1'b0, 1'b1, 32'h0);
    idle();
    step_chk("t4_after", 1'b0, 1'b0, 32'h0);

    // Reset in the second stall cycle
    drv(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    step_chk("t5_prod", 1'b0, 1'b0, 32'h0);
    drv(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    step_chk("t5_s1", 1'b1, 1'b0, 32'h100);
    rst = 1'b1;
    step_chk("t5_rst", 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    step_chk("t5_after", 1'b0, 1'b0, 32'h0);
    idle();
    step_chk("t5_idle", 1'b0, 1'b0, 32'h0);
`else
    // Load-use: one stall cycle
    drv(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
    step_chk("t6_lw", 1'b0, 1'b0, 32'h0);
    drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    step_chk("t6_lu_s", 1'b1, 1'b0, 32'h20);
    step_chk("t6_lu_go", 1'b0, 1'b0, 32'h20);
    idle();
    step_chk("t6_d1", 1'b0, 1'b0, 32'h20);
    step_chk("t6_d2", 1'b0, 1'b0, 32'h0);
    // ALU producer: forwarded, no stall
    drv(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    step_chk("t6_add", 1'b0, 1'b0, 32'h0);
    drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    step_chk("t6_fw", 1'b0, 1'b0, 32'h20);
    idle();
    step_chk("t6_fd1", 1'b0, 1'b0, 32'h20);
    step_chk("t6_fd2", 1'b0, 1'b0, 32'h20);
    step_chk("t6_fd3", 1'b0, 1'b0, 32'h0);
`endif

    // Clean both instances before the FLUSH_CYC=3 section
    rst = 1'b1;
    idle();
    step_chk("pre3", 1'b0, 1'b0, 32'h0);
    rst = 1'b0;

    // FLUSH_CYC=3: three flush cycles, decode ignored in cycles 2-3
    use3 = 1'b1;
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    step_chk("f3_br", 1'b0, 1'b1, 32'h0);
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0);
    step_chk("f3_c2", 1'b0, 1'b1, 32'h0);
    step_chk("f3_c3", 1'b0, 1'b1, 32'h0);
    step_chk("f3_run", 1'b0, 1'b0, 32'h0);
    idle();
    step_chk("f3_iss1", 1'b0, 1'b0, 32'h400);
    step_chk("f3_iss2", 1'b0, 1'b0, 32'h400);
    step_chk("f3_iss3", 1'b0, 1'b0, 32'h400);
    step_chk("f3_iss4", 1'b0, 1'b0, 32'h0);
    // Reset in the middle of a flush returns to RUN
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    step_chk("f3_br2", 1'b0, 1'b1, 32'h0);
    idle();
    rst = 1'b1;
    step_chk("f3_rst", 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    step_chk("f3_clr", 1'b0, 1'b0, 32'h0);
    use3 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
